pc_ifid_stage: RTL and testbench
================================

// Module: pc_ifid_stage
// PURPOSE
//   Fetch-side responder to the load-use stall handshake: owns the PC register and the IF/ID pipeline register.
//   Obeys PCWrite/IFIDwrite from the hazard detection unit and flushes IF/ID on a taken branch from EX/MEM.
//   Exports saturating stall and flush counters for performance debug. Sits between instruction memory and ID.
// PARAMETERS
//   XLEN      64            PC / branch-target width
//   PC_RESET  64'h0         PC value loaded on reset
//   NOP_INSTR 32'h00000013  instruction injected on reset/flush (addi x0,x0,0)
//   CNT_W     16            width of each performance counter
// PORTS
//   clk              in   1      rising-edge clock
//   reset            in   1      asynchronous, active-high reset
//   pc_write_i       in   1      1 = PC may advance (PCWrite from hazard unit)
//   ifid_write_i     in   1      1 = IF/ID may load (IFIDwrite from hazard unit)
//   branch_taken_i   in   1      taken branch/jump resolved downstream; redirect + flush
//   branch_target_i  in   XLEN   redirect address, valid when branch_taken_i=1
//   instr_i          in   32     instruction memory read data for address pc_o (combinational)
//   pc_o             out  XLEN   current fetch PC (to instruction memory)
//   ifid_pc_o        out  XLEN   PC of the instruction held in IF/ID
//   ifid_instr_o     out  32     instruction held in IF/ID
//   ifid_valid_o     out  1      1 = IF/ID holds a real fetched instruction, 0 = bubble
//   stall_cnt_o      out  CNT_W  cycles IF/ID was held by the hazard unit
//   flush_cnt_o      out  CNT_W  number of branch flushes
// BEHAVIOUR
//   Reset (async, immediate): pc_o=PC_RESET, ifid_pc_o=0, ifid_instr_o=NOP_INSTR, ifid_valid_o=0, both counters=0.
//   All state updates on rising clk; outputs are registers only, no combinational input->output path.
//   PC update priority:
//     1. branch_taken_i=1       -> pc_o <= {branch_target_i[XLEN-1:2],2'b00}  (redirect beats stall)
//     2. else pc_write_i=1      -> pc_o <= pc_o + 4  (wraps modulo 2^XLEN, no flag)
//     3. else                   -> pc_o holds
//   IF/ID update priority:
//     1. branch_taken_i=1       -> ifid_instr_o<=NOP_INSTR, ifid_pc_o<=0, ifid_valid_o<=0 (flush)
//     2. else ifid_write_i=1    -> ifid_instr_o<=instr_i, ifid_pc_o<=pc_o, ifid_valid_o<=1
//     3. else                   -> all IF/ID fields hold (stall)
//   pc_write_i and ifid_write_i are honoured independently; mismatched values are legal and not corrected.
//   Latency: instruction at address A appears on ifid_instr_o one clk after pc_o==A with ifid_write_i=1.
//   First edge after reset release with ifid_write_i=1 captures instr_i at PC_RESET, valid=1.
//   stall_cnt_o: +1 on each edge where ifid_write_i=0 and branch_taken_i=0; saturates at all-ones.
//   flush_cnt_o: +1 on each edge where branch_taken_i=1; saturates at all-ones.
//   Branch during stall: flush + redirect win; stall_cnt_o does not increment that cycle.
//   Reset asserted mid-stall or mid-branch: all state returns to reset values on assertion, no partial update.
// TESTING
//   Straight-line: reset, pc/ifid_write=1 for 4 clks, instr_i=mem[pc] -> pc_o 0,4,8,C,10; ifid_pc_o lags by one clk; valid=1 from clk 1.
//   Load-use stall: pc_o=8, drive pc_write=ifid_write=0 for 1 clk -> pc_o stays 8, IF/ID unchanged, stall_cnt_o 0->1.
//   Branch redirect: branch_taken_i=1, target=0x103 -> pc_o=0x100, ifid_instr_o=0x00000013, valid=0, flush_cnt_o+1.
//   Branch during stall: pc_write=ifid_write=0 with branch_taken_i=1, target=0x40 -> pc_o=0x40, flush, stall_cnt_o unchanged.
//   Saturation: CNT_W=4, hold ifid_write=0 for 20 clks -> stall_cnt_o stops at 4'hF.
//   Async reset: assert reset between edges mid-stall -> outputs take reset values before next edge; PC wrap: pc_o=2^XLEN-4 advances to 0.

Source files
------------

// File: rtl/pc_ifid_stage.sv
// pc_ifid_stage: fetch-side owner of the PC and the IF/ID pipeline register.
// The PC advances or holds under PCWrite from the hazard unit. IF/ID loads or
// holds under IFIDwrite. A taken branch from EX/MEM redirects the PC and turns
// IF/ID into a bubble, and it overrides both write enables.
// Two saturating counters record how many cycles IF/ID was stalled and how
// many flushes occurred, for performance debug.
// Every output comes straight from a register, so no input has a
// combinational path to an output.
module pc_ifid_stage #(
    parameter int               XLEN      = 64,
    parameter logic [XLEN-1:0]  PC_RESET  = '0,
    parameter logic [31:0]      NOP_INSTR = 32'h0000_0013,
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pc_write_i,
    input  logic             ifid_write_i,
    input  logic             branch_taken_i,
    input  logic [XLEN-1:0]  branch_target_i,
    input  logic [31:0]      instr_i,
    output logic [XLEN-1:0]  pc_o,
    output logic [XLEN-1:0]  ifid_pc_o,
    output logic [31:0]      ifid_instr_o,
    output logic             ifid_valid_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam logic [XLEN-1:0]  PC_STEP = XLEN'(4);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_ifid_pc;
    logic [31:0]      r_ifid_instr;
    logic             r_ifid_valid;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic [XLEN-1:0]  w_pc_next;
    logic [XLEN-1:0]  w_ifid_pc_next;
    logic [31:0]      w_ifid_instr_next;
    logic             w_ifid_valid_next;
    logic             w_stall_event;
    logic [CNT_W-1:0] w_stall_cnt_next;
    logic [CNT_W-1:0] w_flush_cnt_next;

    // Next PC: a redirect takes priority over a stall. The branch target is
    // forced to word alignment. A sequential advance wraps silently.
    always_comb begin
        w_pc_next = r_pc;
        if (branch_taken_i) begin
            w_pc_next = {branch_target_i[XLEN-1:2], 2'b00};
        end else if (pc_write_i) begin
            w_pc_next = r_pc + PC_STEP;
        end
    end

    // Next IF/ID contents: a flush injects a NOP bubble. Otherwise IF/ID
    // captures the instruction fetched at the current PC, or holds its value.
    always_comb begin
        w_ifid_pc_next    = r_ifid_pc;
        w_ifid_instr_next = r_ifid_instr;
        w_ifid_valid_next = r_ifid_valid;
        if (branch_taken_i) begin
            w_ifid_pc_next    = '0;
            w_ifid_instr_next = NOP_INSTR;
            w_ifid_valid_next = 1'b0;
        end else if (ifid_write_i) begin
            w_ifid_pc_next    = r_pc;
            w_ifid_instr_next = instr_i;
            w_ifid_valid_next = 1'b1;
        end
    end

    // Counter increments: a cycle counts as a stall only if no flush occurs
    // in the same cycle. Both counters stop at all-ones.
    always_comb begin
        w_stall_event    = ~ifid_write_i & ~branch_taken_i;
        w_stall_cnt_next = r_stall_cnt;
        w_flush_cnt_next = r_flush_cnt;
        if (w_stall_event && !(&r_stall_cnt)) begin
            w_stall_cnt_next = r_stall_cnt + CNT_ONE;
        end
        if (branch_taken_i && !(&r_flush_cnt)) begin
            w_flush_cnt_next = r_flush_cnt + CNT_ONE;
        end
    end

    // State registers: reset is asynchronous and reloads every register
    // together, so a reset during a stall or a branch leaves no partial update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc         <= PC_RESET;
            r_ifid_pc    <= '0;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
            r_stall_cnt  <= '0;
            r_flush_cnt  <= '0;
        end else begin
            r_pc         <= w_pc_next;
            r_ifid_pc    <= w_ifid_pc_next;
            r_ifid_instr <= w_ifid_instr_next;
            r_ifid_valid <= w_ifid_valid_next;
            r_stall_cnt  <= w_stall_cnt_next;
            r_flush_cnt  <= w_flush_cnt_next;
        end
    end

    assign pc_o         = r_pc;
    assign ifid_pc_o    = r_ifid_pc;
    assign ifid_instr_o = r_ifid_instr;
    assign ifid_valid_o = r_ifid_valid;
    assign stall_cnt_o  = r_stall_cnt;
    assign flush_cnt_o  = r_flush_cnt;

endmodule

// File: tb/tb_pc_ifid_stage.sv
// tb_pc_ifid_stage: directed stimulus for pc_ifid_stage.
// Two instances receive the same control inputs. One uses 16-bit counters and
// the other uses 4-bit counters, so the bench can show counter saturation.
// Each instance sees instruction memory through its own combinational lookup
// on its own pc_o.
module tb_pc_ifid_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] ifid_pc;
        logic [31:0] instr;
        logic        valid;
        logic [15:0] stall16;
        logic [15:0] flush16;
        logic [3:0]  stall4;
        logic [3:0]  flush4;
    } exp_t;

    // clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        pc_write;
    logic        ifid_write;
    logic        branch_taken;
    logic [63:0] branch_target;

    logic [31:0] instr_a, instr_b;
    logic [63:0] pc_a, pc_b, ifid_pc_a, ifid_pc_b;
    logic [31:0] ifid_instr_a, ifid_instr_b;
    logic        valid_a, valid_b;
    logic [15:0] stall_a, flush_a;
    logic [3:0]  stall_b, flush_b;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return 32'hA500_0000 ^ a[31:0] ^ {a[63:48], 16'h0000};
    endfunction

    assign instr_a = mem_word(pc_a);
    assign instr_b = mem_word(pc_b);

    pc_ifid_stage #(.XLEN(64), .PC_RESET(64'h0), .NOP_INSTR(NOP), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset),
        .pc_write_i(pc_write), .ifid_write_i(ifid_write),
        .branch_taken_i(branch_taken), .branch_target_i(branch_target),
        .instr_i(instr_a),
        .pc_o(pc_a), .ifid_pc_o(ifid_pc_a), .ifid_instr_o(ifid_instr_a),
        .ifid_valid_o(valid_a), .stall_cnt_o(stall_a), .flush_cnt_o(flush_a)
    );

    pc_ifid_stage #(.XLEN(64), .PC_RESET(64'h0), .NOP_INSTR(NOP), .CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset),
        .pc_write_i(pc_write), .ifid_write_i(ifid_write),
        .branch_taken_i(branch_taken), .branch_target_i(branch_target),
        .instr_i(instr_b),
        .pc_o(pc_b), .ifid_pc_o(ifid_pc_b), .ifid_instr_o(ifid_instr_b),
        .ifid_valid_o(valid_b), .stall_cnt_o(stall_b), .flush_cnt_o(flush_b)
    );

    // scoreboard state
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    event ev_sample;

    // reference model of the architectural state
    logic [63:0] m_pc, m_ifid_pc;
    logic [31:0] m_instr;
    logic        m_valid;
    logic [15:0] m_stall16, m_flush16;
    logic [3:0]  m_stall4, m_flush4;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 64'h0; m_ifid_pc = 64'h0; m_instr = NOP; m_valid = 1'b0;
        m_stall16 = '0; m_flush16 = '0; m_stall4 = '0; m_flush4 = '0;
    endtask

    task automatic push_exp();
        exp_t e;
        e.pc = m_pc; e.ifid_pc = m_ifid_pc; e.instr = m_instr; e.valid = m_valid;
        e.stall16 = m_stall16; e.flush16 = m_flush16;
        e.stall4 = m_stall4; e.flush4 = m_flush4;
        exp_q.push_back(e);
    endtask

    // driver: apply one cycle of inputs, let one edge pass, push expected state
    task automatic step(input logic pw, input logic iw, input logic br, input logic [63:0] tgt);
        logic [63:0] old_pc;
        pc_write = pw; ifid_write = iw; branch_taken = br; branch_target = tgt;
        @(posedge clk);
        #1;
        old_pc = m_pc;
        if (br) begin
            m_pc = {tgt[63:2], 2'b00};
            m_ifid_pc = 64'h0; m_instr = NOP; m_valid = 1'b0;
        end else begin
            if (pw) m_pc = old_pc + 64'd4;
            if (iw) begin
                m_ifid_pc = old_pc; m_instr = mem_word(old_pc); m_valid = 1'b1;
            end
        end
        if (!iw && !br) begin
            if (m_stall16 != 16'hFFFF) m_stall16 = m_stall16 + 16'd1;
            if (m_stall4 != 4'hF) m_stall4 = m_stall4 + 4'd1;
        end
        if (br) begin
            if (m_flush16 != 16'hFFFF) m_flush16 = m_flush16 + 16'd1;
            if (m_flush4 != 4'hF) m_flush4 = m_flush4 + 4'd1;
        end
        push_exp();
    endtask

    // assert reset between edges and have the monitor sample before the next edge
    task automatic async_reset_midcycle();
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        model_reset();
        push_exp();
        -> ev_sample;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // monitor: pop expected state and compare it with both instances
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or ev_sample);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc_o",         pc_a,                 e.pc);
                chk("pc_o_cnt4",    pc_b,                 e.pc);
                chk("ifid_pc_o",    ifid_pc_a,            e.ifid_pc);
                chk("ifid_instr_o", {32'h0, ifid_instr_a}, {32'h0, e.instr});
                chk("ifid_valid_o", {63'h0, valid_a},      {63'h0, e.valid});
                chk("ifid_valid_o_cnt4", {63'h0, valid_b}, {63'h0, e.valid});
                chk("stall_cnt16",  {48'h0, stall_a},      {48'h0, e.stall16});
                chk("flush_cnt16",  {48'h0, flush_a},      {48'h0, e.flush16});
                chk("stall_cnt4",   {60'h0, stall_b},      {60'h0, e.stall4});
                chk("flush_cnt4",   {60'h0, flush_b},      {60'h0, e.flush4});
            end
        end
    end

    // stimulus
    initial begin
        reset = 1'b1;
        pc_write = 1'b0; ifid_write = 1'b0; branch_taken = 1'b0; branch_target = '0;
        #2;
        model_reset();
        push_exp();
        -> ev_sample;
        @(posedge clk);
        #1 reset = 1'b0;

        // straight line: pc 0 -> 4 -> 8 -> C -> 10
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 64'h0);
        // load-use stall at pc 0x10
        step(1'b0, 1'b0, 1'b0, 64'h0);
        step(1'b1, 1'b1, 1'b0, 64'h0);
        // branch redirect to 0x103, which aligns to 0x100
        step(1'b1, 1'b1, 1'b1, 64'h103);
        step(1'b1, 1'b1, 1'b0, 64'h0);
        step(1'b1, 1'b1, 1'b0, 64'h0);
        // branch during stall
        step(1'b0, 1'b0, 1'b1, 64'h40);
        step(1'b1, 1'b1, 1'b0, 64'h0);
        // mismatched enables are honoured independently
        step(1'b1, 1'b0, 1'b0, 64'h0);
        step(1'b0, 1'b1, 1'b0, 64'h0);
        // long stall: 4-bit counter saturates at F
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 64'h0);
        step(1'b1, 1'b1, 1'b0, 64'h0);
        // PC wrap: redirect to the top word, then advance to 0
        step(1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        step(1'b1, 1'b1, 1'b0, 64'h0);
        step(1'b1, 1'b1, 1'b0, 64'h0);
        // async reset in the middle of a stall
        step(1'b0, 1'b0, 1'b0, 64'h0);
        async_reset_midcycle();
        // first edge after reset captures the instruction at PC_RESET
        step(1'b1, 1'b1, 1'b0, 64'h0);
        step(1'b1, 1'b1, 1'b0, 64'h0);

        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
